operand_fetch: RTL and testbench
================================

# operand_fetch

Operand-fetch stage of the RISC datapath, sitting directly upstream of the barrel shifter. It holds the 8×16 general-purpose register file. On each accepted instruction request it reads the two source registers over a single read port in two consecutive cycles and latches them into the A and B operand registers. It then presents B (the shifter input), A, and the latched opcode/shift fields to the shifter/ALU stage under a valid/take handshake.

## Interface
Parameters:
- `WIDTH`, 16, data width of registers and operands.
- `NREGS`, 8, number of general-purpose registers; register index width is log2(NREGS) = 3.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request to fetch operands; sampled only while `ready`=1.
- `rn`  in  3  register index for operand A.
- `rm`  in  3  register index for operand B.
- `opcode_in`  in  3  instruction opcode, latched on accept.
- `shift_in`  in  2  shift field, latched on accept.
- `ready`  out  1  high only in IDLE.
- `write`  in  1  register-file write enable; valid in any state.
- `writenum`  in  3  register index to write.
- `data_in`  in  WIDTH  write data (writeback from downstream).
- `valid`  out  1  operands and fields are stable and valid.
- `take`  in  1  consumer accepts the outputs; meaningful only while `valid`=1.
- `a_out`  out  WIDTH  latched operand A.
- `b_out`  out  WIDTH  latched operand B; drives the shifter `in`.
- `opcode_out`  out  3  latched opcode.
- `shift_out`  out  2  latched shift field; forced to 2'b00 for memory opcodes.

## Operation
- FSM states: IDLE, FETCH_A, FETCH_B, VALID.
- IDLE:
  - `ready`=1.
  - On `start`, latch `rn`, `rm`, `opcode_in`, `shift_in`, then go to FETCH_A.
- FETCH_A: A ← R[rn_q]; go to FETCH_B.
- FETCH_B: B ← R[rm_q]; go to VALID.
- VALID:
  - `valid`=1; outputs stay constant.
  - `take`=1 returns to IDLE; otherwise remain in VALID indefinitely.
- `start` outside IDLE is ignored. The request is not queued.
- `take` outside VALID is ignored.
- Shift override: if the latched opcode is OP_LDR (3'b011) or OP_STR (3'b100), `shift_out`=2'b00. Otherwise `shift_out` equals the latched shift field.
- Write port:
  - When `write`=1, R[writenum] ← data_in at the clock edge, independent of FSM state.
  - All registers are writable, including R0. There is no hardwired zero.
- Write/read collision: if a write targets the register being read in FETCH_A or FETCH_B in that same cycle, the operand latches `data_in` (bypass), not the old contents.
- `rn`==`rm` is legal; A and B receive the same value, subject to any intervening write.
- Writes after an operand has been latched do not alter `a_out` or `b_out`.

## Timing
- Reset:
  - State goes to IDLE.
  - `ready`=1, `valid`=0.
  - `a_out`, `b_out`, `opcode_out`, `shift_out` = 0.
  - All registers R0–R7 = 0.
- Reset has priority over `start`, `take` and `write`. Reset mid-fetch or in VALID aborts the fetch with no output.
- Latency: with `start` sampled at edge N, the FSM is in FETCH_A after N and FETCH_B after N+1. `valid` rises after edge N+2 (3 cycles).
- Back-to-back: with `take` at edge M, `ready`=1 after M and a new `start` can be sampled at M+1. Minimum throughput is one request per 4 cycles.
- `ready` and `valid` are registered state decodes; no combinational path from inputs.
- Write-to-read: a write at edge K is visible to a FETCH read at edge K via bypass, and to any later read from the array.

## Structure
- Shared package `rm_pkg`:
  - state encoding localparams `S_IDLE`, `S_FETCH_A`, `S_FETCH_B`, `S_VALID`;
  - opcode constants `OP_LDR`=3'b011, `OP_STR`=3'b100;
  - `WIDTH` default.
- Sub-module `regfile`: NREGS×WIDTH array with one synchronous write port and one combinational read port (`readnum` → `data_out`).
- Top level holds the FSM, bypass mux, operand latches and shift-override logic.

## Test plan
1. Reset, then write R2=16'h00F0 and R5=16'h8001. Send `start` with rn=2, rm=5, opcode=3'b101, shift=2'b11. Expect `valid` 3 cycles later, with a_out=16'h00F0, b_out=16'h8001, shift_out=2'b11.
2. Same fetch with opcode=3'b011 and shift=2'b10. Expect shift_out=2'b00 and opcode_out=3'b011.
3. Collision: in the FETCH_B cycle, write R5=16'h1234 with rm=5. Expect b_out=16'h1234. A write to R2 in the FETCH_B cycle does not change a_out.
4. Hold `take`=0 for 5 cycles in VALID while pulsing `start` and writing R2. Outputs stay constant and `ready`=0. After `take`, `ready`=1 on the next cycle.
5. Assert `reset` during FETCH_A after R3=16'hBEEF was written. Expect `valid`=0, `ready`=1, all outputs 0, and a subsequent fetch of R3 returns 0.
6. Back-to-back: send `take` and `start` on consecutive cycles for rn=rm=7 holding 16'hA5A5. Expect a_out=b_out=16'hA5A5, with `valid` rising every 4 cycles.

Source files
------------

// File: rtl/rm_pkg.sv
// Shared definitions for the operand-fetch stage: FSM states, memory opcodes
// and the shift-field override rule applied to memory instructions.
package rm_pkg;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned NREGS = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_FETCH_A = 2'd1,
        S_FETCH_B = 2'd2,
        S_VALID   = 2'd3
    } state_e;

    localparam logic [2:0] OP_LDR = 3'b011;
    localparam logic [2:0] OP_STR = 3'b100;

    // Memory instructions never shift their operand.
    function automatic logic [1:0] eff_shift(input logic [2:0] op, input logic [1:0] sh);
        return ((op == OP_LDR) || (op == OP_STR)) ? 2'b00 : sh;
    endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Request, register-file write and operand-output signals of the operand-fetch stage.
interface operand_fetch_if #(
    parameter int unsigned WIDTH = rm_pkg::WIDTH,
    parameter int unsigned NREGS = rm_pkg::NREGS
);
    localparam int unsigned IW = $clog2(NREGS);

    logic             start;
    logic [IW-1:0]    rn;
    logic [IW-1:0]    rm;
    logic [2:0]       opcode_in;
    logic [1:0]       shift_in;
    logic             ready;
    logic             write;
    logic [IW-1:0]    writenum;
    logic [WIDTH-1:0] data_in;
    logic             valid;
    logic             take;
    logic [WIDTH-1:0] a_out;
    logic [WIDTH-1:0] b_out;
    logic [2:0]       opcode_out;
    logic [1:0]       shift_out;

    modport master (
        output start, rn, rm, opcode_in, shift_in, write, writenum, data_in, take,
        input  ready, valid, a_out, b_out, opcode_out, shift_out
    );

    modport slave (
        input  start, rn, rm, opcode_in, shift_in, write, writenum, data_in, take,
        output ready, valid, a_out, b_out, opcode_out, shift_out
    );

endinterface

// File: rtl/regfile.sv
// General-purpose register file: one synchronous write port, one combinational
// read port; reset clears every register.
module regfile #(
    parameter int unsigned WIDTH = rm_pkg::WIDTH,
    parameter int unsigned NREGS = rm_pkg::NREGS
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     write,
    input  logic [$clog2(NREGS)-1:0] writenum,
    input  logic [WIDTH-1:0]         data_in,
    input  logic [$clog2(NREGS)-1:0] readnum,
    output logic [WIDTH-1:0]         data_out
);

    logic [WIDTH-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (write) begin
            regs_q[writenum] <= data_in;
        end
    end

    assign data_out = regs_q[readnum];

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch stage: reads A then B through one register-file port, latches
// them with the opcode/shift fields, and holds them under a valid/take handshake.
module operand_fetch
    import rm_pkg::*;
#(
    parameter int unsigned WIDTH = rm_pkg::WIDTH,
    parameter int unsigned NREGS = rm_pkg::NREGS
) (
    input  logic            clk,
    input  logic            reset,
    operand_fetch_if.slave  bus
);

    localparam int unsigned IW = $clog2(NREGS);

    state_e           state_q, state_d;
    logic [IW-1:0]    rn_q, rm_q;
    logic [2:0]       opcode_q;
    logic [1:0]       shift_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [IW-1:0]    readnum;
    logic [WIDTH-1:0] rf_data;
    logic [WIDTH-1:0] fetch_data;

    regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
        .clk      (clk),
        .reset    (reset),
        .write    (bus.write),
        .writenum (bus.writenum),
        .data_in  (bus.data_in),
        .readnum  (readnum),
        .data_out (rf_data)
    );

    // A same-cycle write to the register being fetched wins over the array contents.
    assign readnum    = (state_q == S_FETCH_A) ? rn_q : rm_q;
    assign fetch_data = (bus.write && (bus.writenum == readnum)) ? bus.data_in : rf_data;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (bus.start) state_d = S_FETCH_A;
            S_FETCH_A: state_d = S_FETCH_B;
            S_FETCH_B: state_d = S_VALID;
            S_VALID:   if (bus.take) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rn_q     <= '0;
            rm_q     <= '0;
            opcode_q <= '0;
            shift_q  <= '0;
            a_q      <= '0;
            b_q      <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IDLE) && bus.start) begin
                rn_q     <= bus.rn;
                rm_q     <= bus.rm;
                opcode_q <= bus.opcode_in;
                shift_q  <= bus.shift_in;
            end
            if (state_q == S_FETCH_A) a_q <= fetch_data;
            if (state_q == S_FETCH_B) b_q <= fetch_data;
        end
    end

    assign bus.ready      = (state_q == S_IDLE);
    assign bus.valid      = (state_q == S_VALID);
    assign bus.a_out      = a_q;
    assign bus.b_out      = b_q;
    assign bus.opcode_out = opcode_q;
    assign bus.shift_out  = eff_shift(opcode_q, shift_q);

endmodule

// File: tb/tb_operand_fetch.sv
// Directed and randomized checks of operand_fetch against a register-array
// model that applies writes at each clock edge.
module tb_operand_fetch;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    operand_fetch_if #(.WIDTH(16), .NREGS(8)) bus ();

    operand_fetch #(.WIDTH(16), .NREGS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [15:0] mem [8];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          last_valid_cyc = -1;
    logic [15:0] exp_a, exp_b;
    logic [2:0]  exp_op;
    logic [1:0]  exp_sh;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock edge; the model applies whatever write/reset was presented to it.
    task automatic cycle();
        logic        w, r;
        logic [2:0]  wn;
        logic [15:0] wd;
        w = bus.write; wn = bus.writenum; wd = bus.data_in; r = reset;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            for (int i = 0; i < 8; i++) mem[i] = '0;
        end else if (w) begin
            mem[wn] = wd;
        end
    endtask

    task automatic do_write(input logic [2:0] n, input logic [15:0] d);
        bus.write = 1'b1; bus.writenum = n; bus.data_in = d;
        cycle();
        bus.write = 1'b0;
    endtask

    function automatic logic [1:0] ref_shift(input logic [2:0] op, input logic [1:0] sh);
        return (op == 3'd3 || op == 3'd4) ? 2'd0 : sh;
    endfunction

    task automatic fetch(input logic [2:0] rn, input logic [2:0] rm, input logic [2:0] op,
                         input logic [1:0] sh,
                         input logic wa, input logic [2:0] wan, input logic [15:0] wad,
                         input logic wb, input logic [2:0] wbn, input logic [15:0] wbd,
                         input logic check_rate);
        int lat;
        chk("ready_before_start", {31'd0, bus.ready}, 32'd1);
        bus.start = 1'b1; bus.rn = rn; bus.rm = rm; bus.opcode_in = op; bus.shift_in = sh;
        cycle();
        bus.start = 1'b0;
        bus.rn = 3'($urandom); bus.rm = 3'($urandom);
        bus.opcode_in = 3'($urandom); bus.shift_in = 2'($urandom);
        chk("ready_during_fetch", {30'd0, bus.ready, bus.valid}, 32'd0);
        bus.write = wa; bus.writenum = wan; bus.data_in = wad;
        cycle();
        exp_a = mem[rn];
        bus.write = wb; bus.writenum = wbn; bus.data_in = wbd;
        cycle();
        exp_b = mem[rm];
        bus.write = 1'b0;
        exp_op = op;
        exp_sh = ref_shift(op, sh);
        lat = 3;
        while (!bus.valid && lat < 12) begin
            cycle();
            lat++;
        end
        chk("valid_latency", lat, 32'd3);
        if (check_rate && last_valid_cyc >= 0) chk("b2b_interval", cyc - last_valid_cyc, 32'd4);
        last_valid_cyc = cyc;
        chk("a_out", {16'd0, bus.a_out}, {16'd0, exp_a});
        chk("b_out", {16'd0, bus.b_out}, {16'd0, exp_b});
        chk("opcode_out", {29'd0, bus.opcode_out}, {29'd0, exp_op});
        chk("shift_out", {30'd0, bus.shift_out}, {30'd0, exp_sh});
        chk("ready_in_valid", {31'd0, bus.ready}, 32'd0);
    endtask

    task automatic do_take();
        bus.take = 1'b1;
        cycle();
        bus.take = 1'b0;
        chk("ready_after_take", {30'd0, bus.ready, bus.valid}, 32'd2);
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.take = 1'b0; bus.write = 1'b0;
        bus.rn = '0; bus.rm = '0; bus.opcode_in = '0; bus.shift_in = '0;
        bus.writenum = '0; bus.data_in = '0;
        cycle();
        cycle();
        reset = 1'b0;
        chk("reset_ready_valid", {30'd0, bus.ready, bus.valid}, 32'd2);
        chk("reset_outputs", {bus.a_out, bus.b_out}, 32'd0);
        chk("reset_fields", {27'd0, bus.opcode_out, bus.shift_out}, 32'd0);

        // Basic fetch, then memory-opcode shift override.
        do_write(3'd2, 16'h00F0);
        do_write(3'd5, 16'h8001);
        fetch(3'd2, 3'd5, 3'b101, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        chk("t1_a", {16'd0, bus.a_out}, 32'h00F0);
        chk("t1_b", {16'd0, bus.b_out}, 32'h8001);
        do_take();
        fetch(3'd2, 3'd5, 3'b011, 2'b10, 0, 0, 0, 0, 0, 0, 0);
        chk("t2_shift_ldr", {30'd0, bus.shift_out}, 32'd0);
        do_take();
        fetch(3'd2, 3'd5, 3'b100, 2'b01, 0, 0, 0, 0, 0, 0, 0);
        do_take();

        // Same-cycle bypass on B, and a late write to A's source that must not leak.
        fetch(3'd2, 3'd5, 3'b000, 2'b01, 0, 0, 0, 1, 3'd5, 16'h1234, 0);
        chk("t3_b_bypass", {16'd0, bus.b_out}, 32'h1234);
        do_take();
        fetch(3'd2, 3'd5, 3'b000, 2'b01, 0, 0, 0, 1, 3'd2, 16'hDEAD, 0);
        chk("t3_a_unchanged", {16'd0, bus.a_out}, 32'h00F0);
        do_take();
        fetch(3'd2, 3'd5, 3'b001, 2'b00, 1, 3'd2, 16'h5A5A, 0, 0, 0, 0);
        chk("t3_a_bypass", {16'd0, bus.a_out}, 32'h5A5A);

        // Hold in VALID while start and writes are ignored.
        for (int k = 0; k < 5; k++) begin
            bus.start = 1'b1; bus.rn = 3'($urandom); bus.rm = 3'($urandom);
            bus.write = 1'b1; bus.writenum = 3'd2; bus.data_in = 16'($urandom);
            cycle();
            chk("hold_hs", {30'd0, bus.ready, bus.valid}, 32'd1);
            chk("hold_ab", {bus.a_out, bus.b_out}, {exp_a, exp_b});
            chk("hold_fields", {27'd0, bus.opcode_out, bus.shift_out}, {27'd0, exp_op, exp_sh});
        end
        bus.start = 1'b0; bus.write = 1'b0;
        do_take();

        // Reset during FETCH_A clears the register file and outputs.
        do_write(3'd3, 16'hBEEF);
        bus.start = 1'b1; bus.rn = 3'd3; bus.rm = 3'd3; bus.opcode_in = 3'd6; bus.shift_in = 2'd1;
        cycle();
        bus.start = 1'b0;
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        chk("rst_mid_hs", {30'd0, bus.ready, bus.valid}, 32'd2);
        chk("rst_mid_ab", {bus.a_out, bus.b_out}, 32'd0);
        chk("rst_mid_fields", {27'd0, bus.opcode_out, bus.shift_out}, 32'd0);
        fetch(3'd3, 3'd3, 3'd2, 2'd2, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_r3_zero", {16'd0, bus.a_out}, 32'd0);
        do_take();

        // Back-to-back requests: one result every 4 cycles.
        do_write(3'd7, 16'hA5A5);
        last_valid_cyc = -1;
        for (int k = 0; k < 3; k++) begin
            fetch(3'd7, 3'd7, 3'd0, 2'd3, 0, 0, 0, 0, 0, 0, 1);
            chk("b2b_ab", {bus.a_out, bus.b_out}, 32'hA5A5A5A5);
            do_take();
        end

        // Random writes, fetches with random collisions and random hold times.
        for (int k = 0; k < 30; k++) begin
            for (int j = 0; j < int'($urandom_range(2, 0)); j++)
                do_write(3'($urandom), 16'($urandom));
            fetch(3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom),
                  1'($urandom), 3'($urandom), 16'($urandom),
                  1'($urandom), 3'($urandom), 16'($urandom), 0);
            for (int j = 0; j < int'($urandom_range(2, 0)); j++) begin
                bus.write = 1'($urandom); bus.writenum = 3'($urandom); bus.data_in = 16'($urandom);
                cycle();
                bus.write = 1'b0;
                chk("rand_hold_ab", {bus.a_out, bus.b_out}, {exp_a, exp_b});
            end
            do_take();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
